// File: rtl/adc_level_sync.sv
// adc_level_sync: gates the continuous ADC sample stream into one AXI-Stream
// packet per START command. The packet either opens immediately or after a
// run of samples above a start threshold. It closes at DSIZE samples or after
// a run of samples below a stop threshold.
module adc_level_sync #(
  parameter int DW = 16,
  parameter int CW = 32,
  parameter int NW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] adc_data,
  input  logic          adc_valid,
  input  logic          cfg_start,
  input  logic          cfg_ls,
  input  logic [CW-1:0] cfg_dsize,
  input  logic [DW-1:0] cfg_start_thr,
  input  logic [DW-1:0] cfg_stop_thr,
  input  logic [NW-1:0] cfg_n_start,
  input  logic [NW-1:0] cfg_n_stop,
  output logic [DW-1:0] m_axis_tdata,
  output logic          m_axis_tvalid,
  output logic          m_axis_tlast,
  input  logic          m_axis_tready,
  output logic          sr_pc,
  output logic          sr_busy,
  output logic          sr_ovf,
  output logic [CW-1:0] pkt_len
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Configuration captured at START and held for the whole packet
  logic          ls_q;
  logic [CW-1:0] dsize_q;
  logic [DW-1:0] start_thr_q;
  logic [DW-1:0] stop_thr_q;
  logic [NW-1:0] n_start_eff_q;
  logic [NW-1:0] n_stop_eff_q;

  // Run and sample counters
  logic [NW-1:0] run_cnt_q;
  logic [NW-1:0] stop_cnt_q;
  logic [CW-1:0] samp_cnt_q;

  // Output register and status
  logic [DW-1:0] tdata_q;
  logic          tvalid_q;
  logic          tlast_q;
  logic          sr_pc_q;
  logic          sr_ovf_q;
  logic [CW-1:0] pkt_len_q;

  // Combinational helpers
  logic          start_accept;
  logic          above;
  logic          below;
  logic [NW-1:0] run_inc;
  logic [NW-1:0] stop_inc;
  logic [CW-1:0] cnt_inc;
  logic          start_hit;
  logic          size_hit;
  logic          stop_hit;
  logic          capture_last;
  logic          can_load;
  logic          emit;
  logic          emit_last;

  assign start_accept = (state_q == S_IDLE) && cfg_start && (cfg_dsize != '0);
  assign above        = $signed(adc_data) > $signed(start_thr_q);
  assign below        = $signed(adc_data) < $signed(stop_thr_q);
  assign run_inc      = run_cnt_q + NW'(1);
  assign stop_inc     = stop_cnt_q + NW'(1);
  assign cnt_inc      = samp_cnt_q + CW'(1);
  assign start_hit    = above && (run_inc == n_start_eff_q);
  assign size_hit     = (cnt_inc >= dsize_q);
  assign stop_hit     = ls_q && below && (stop_inc == n_stop_eff_q);
  assign capture_last = size_hit || stop_hit;
  // The register can take a new beat when empty or being drained this cycle
  assign can_load     = !tvalid_q || m_axis_tready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_accept) state_d = cfg_ls ? S_ARMED : S_CAPTURE;
      end
      S_ARMED: begin
        // A one-sample packet closes on its trigger sample
        if (adc_valid && start_hit)
          state_d = (dsize_q == CW'(1)) ? S_DONE : S_CAPTURE;
      end
      S_CAPTURE: begin
        if (adc_valid && capture_last) state_d = S_DONE;
      end
      S_DONE: begin
        if (!tvalid_q || m_axis_tready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: which samples are emitted and which one ends the packet
  always_comb begin
    emit      = 1'b0;
    emit_last = 1'b0;
    sr_busy   = (state_q != S_IDLE);
    unique case (state_q)
      S_ARMED: begin
        emit      = adc_valid && start_hit;
        emit_last = (dsize_q == CW'(1));
      end
      S_CAPTURE: begin
        emit      = adc_valid;
        emit_last = capture_last;
      end
      default: begin
        emit      = 1'b0;
        emit_last = 1'b0;
      end
    endcase
  end

  // Config latch, run/sample counters, packet completion status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ls_q          <= 1'b0;
      dsize_q       <= '0;
      start_thr_q   <= '0;
      stop_thr_q    <= '0;
      n_start_eff_q <= '0;
      n_stop_eff_q  <= '0;
      run_cnt_q     <= '0;
      stop_cnt_q    <= '0;
      samp_cnt_q    <= '0;
      sr_pc_q       <= 1'b0;
      pkt_len_q     <= '0;
    end else if (start_accept) begin
      ls_q          <= cfg_ls;
      dsize_q       <= cfg_dsize;
      start_thr_q   <= cfg_start_thr;
      stop_thr_q    <= cfg_stop_thr;
      n_start_eff_q <= (cfg_n_start == '0) ? NW'(1) : cfg_n_start;
      n_stop_eff_q  <= (cfg_n_stop == '0) ? NW'(1) : cfg_n_stop;
      run_cnt_q     <= '0;
      stop_cnt_q    <= '0;
      samp_cnt_q    <= '0;
      sr_pc_q       <= 1'b0;
    end else if (adc_valid && state_q == S_ARMED) begin
      run_cnt_q <= above ? run_inc : '0;
      if (start_hit) begin
        samp_cnt_q <= CW'(1);
        if (dsize_q == CW'(1)) begin
          pkt_len_q <= CW'(1);
          sr_pc_q   <= 1'b1;
        end
      end
    end else if (adc_valid && state_q == S_CAPTURE) begin
      // Leaving CAPTURE on size_hit keeps the count from passing dsize
      samp_cnt_q <= cnt_inc;
      stop_cnt_q <= (ls_q && below) ? stop_inc : '0;
      if (capture_last) begin
        pkt_len_q <= cnt_inc;
        sr_pc_q   <= 1'b1;
      end
    end
  end

  // Single-stage output register; a sample arriving while a beat is stalled is dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      sr_ovf_q <= 1'b0;
    end else begin
      if (start_accept) sr_ovf_q <= 1'b0;
      if (emit) begin
        if (can_load) begin
          tdata_q  <= adc_data;
          tvalid_q <= 1'b1;
          tlast_q  <= emit_last;
        end else begin
          sr_ovf_q <= 1'b1;
          // Terminate the packet on the held beat if the dropped one was last
          if (emit_last) tlast_q <= 1'b1;
        end
      end else if (tvalid_q && m_axis_tready) begin
        tvalid_q <= 1'b0;
        tlast_q  <= 1'b0;
      end
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign sr_pc         = sr_pc_q;
  assign sr_ovf        = sr_ovf_q;
  assign pkt_len       = pkt_len_q;

endmodule

// File: tb/tb_adc_level_sync.sv
// Directed testbench for adc_level_sync.
module tb_adc_level_sync;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] adc_data = '0;
  logic        adc_valid = 1'b0;
  logic        cfg_start = 1'b0;
  logic        cfg_ls = 1'b0;
  logic [31:0] cfg_dsize = '0;
  logic [15:0] cfg_start_thr = '0;
  logic [15:0] cfg_stop_thr = '0;
  logic [15:0] cfg_n_start = '0;
  logic [15:0] cfg_n_stop = '0;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready = 1'b1;
  logic        sr_pc;
  logic        sr_busy;
  logic        sr_ovf;
  logic [31:0] pkt_len;

  int total = 0;
  int bad   = 0;

  logic [15:0] beat_d[$];
  logic        beat_l[$];

  logic [15:0] exp2 [7];
  logic [15:0] exp4 [7];

  adc_level_sync dut (
    .clk           (clk),
    .rst           (rst),
    .adc_data      (adc_data),
    .adc_valid     (adc_valid),
    .cfg_start     (cfg_start),
    .cfg_ls        (cfg_ls),
    .cfg_dsize     (cfg_dsize),
    .cfg_start_thr (cfg_start_thr),
    .cfg_stop_thr  (cfg_stop_thr),
    .cfg_n_start   (cfg_n_start),
    .cfg_n_stop    (cfg_n_stop),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .sr_pc         (sr_pc),
    .sr_busy       (sr_busy),
    .sr_ovf        (sr_ovf),
    .pkt_len       (pkt_len)
  );

  always #5 clk = ~clk;

  // Record every beat that will handshake on the coming rising edge
  always @(negedge clk) begin
    if (!rst && m_axis_tvalid && m_axis_tready) begin
      beat_d.push_back(m_axis_tdata);
      beat_l.push_back(m_axis_tlast);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    adc_data  = v[15:0];
    adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
  endtask

  task automatic pulse_start();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    m_axis_tready = 1'b1;
    while (sr_busy && n < 50) begin
      tick();
      n++;
    end
    tick();
    chk(tag, {31'd0, sr_busy}, 32'd0);
  endtask

  task automatic clear_beats();
    beat_d.delete();
    beat_l.delete();
  endtask

  task automatic count_last(output int n);
    n = 0;
    foreach (beat_l[i]) if (beat_l[i]) n++;
  endtask

  initial begin
    int nl;
    exp2 = '{16'd220, 16'd230, 16'd5, 16'hFFEC, 16'd0, 16'hFFE2, 16'hFFD8};
    exp4 = '{16'd0, 16'd1, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9};

    // Reset state
    tick(); tick();
    chk("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("rst_tlast",  {31'd0, m_axis_tlast}, 32'd0);
    chk("rst_tdata",  {16'd0, m_axis_tdata}, 32'd0);
    chk("rst_pc",     {31'd0, sr_pc}, 32'd0);
    chk("rst_busy",   {31'd0, sr_busy}, 32'd0);
    chk("rst_ovf",    {31'd0, sr_ovf}, 32'd0);
    chk("rst_len",    pkt_len, 32'd0);
    rst = 1'b0;
    tick();

    // Immediate capture, dsize=8, samples 0..7
    clear_beats();
    cfg_ls = 1'b0; cfg_dsize = 32'd8;
    pulse_start();
    chk("t1_busy", {31'd0, sr_busy}, 32'd1);
    chk("t1_pre_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      send(i);
      chk($sformatf("t1_tvalid%0d", i), {31'd0, m_axis_tvalid}, 32'd1);
      chk($sformatf("t1_tdata%0d", i), {16'd0, m_axis_tdata}, i);
      chk($sformatf("t1_tlast%0d", i), {31'd0, m_axis_tlast}, (i == 7) ? 32'd1 : 32'd0);
    end
    chk("t1_pc", {31'd0, sr_pc}, 32'd1);
    chk("t1_len", pkt_len, 32'd8);
    wait_idle("t1_idle");
    chk("t1_nbeats", beat_d.size(), 32'd8);
    chk("t1_ovf", {31'd0, sr_ovf}, 32'd0);

    // Level sync: start on run of 3 above 100, stop on run of 2 below -10
    clear_beats();
    cfg_ls = 1'b1; cfg_dsize = 32'd1000;
    cfg_start_thr = 16'd100; cfg_n_start = 16'd3;
    cfg_stop_thr = 16'hFFF6; cfg_n_stop = 16'd2;
    pulse_start();
    send(50); send(150); send(160); send(90); send(200); send(210);
    chk("t2_armed_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("t2_armed_busy", {31'd0, sr_busy}, 32'd1);
    send(220);
    chk("t2_first", {16'd0, m_axis_tdata}, 32'd220);
    send(230); send(5); send(-20); send(0); send(-30); send(-40);
    chk("t2_last_tlast", {31'd0, m_axis_tlast}, 32'd1);
    chk("t2_len", pkt_len, 32'd7);
    send(-50);
    wait_idle("t2_idle");
    chk("t2_nbeats", beat_d.size(), 32'd7);
    for (int i = 0; i < 7 && i < beat_d.size(); i++)
      chk($sformatf("t2_beat%0d", i), {16'd0, beat_d[i]}, {16'd0, exp2[i]});
    count_last(nl);
    chk("t2_nlast", nl, 32'd1);
    if (beat_l.size() == 7) chk("t2_tlast_pos", {31'd0, beat_l[6]}, 32'd1);

    // Size and stop limits reached on the same sample
    clear_beats();
    cfg_dsize = 32'd4; cfg_n_start = 16'd1;
    pulse_start();
    send(150); send(5); send(-20); send(-30); send(-50);
    chk("t3_len", pkt_len, 32'd4);
    wait_idle("t3_idle");
    chk("t3_nbeats", beat_d.size(), 32'd4);
    count_last(nl);
    chk("t3_nlast", nl, 32'd1);

    // Backpressure: tready low for 3 cycles mid-capture
    clear_beats();
    cfg_ls = 1'b0; cfg_dsize = 32'd10;
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      m_axis_tready = !(i >= 2 && i <= 4);
      send(i);
    end
    chk("t4_ovf", {31'd0, sr_ovf}, 32'd1);
    chk("t4_len", pkt_len, 32'd10);
    wait_idle("t4_idle");
    chk("t4_nbeats", beat_d.size(), 32'd7);
    for (int i = 0; i < 7 && i < beat_d.size(); i++)
      chk($sformatf("t4_beat%0d", i), {16'd0, beat_d[i]}, {16'd0, exp4[i]});

    // Dropped last sample forces tlast onto the held beat
    clear_beats();
    cfg_dsize = 32'd3;
    m_axis_tready = 1'b0;
    pulse_start();
    send(40); send(41); send(42);
    chk("t5_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
    chk("t5_tdata", {16'd0, m_axis_tdata}, 32'd40);
    chk("t5_tlast", {31'd0, m_axis_tlast}, 32'd1);
    chk("t5_busy", {31'd0, sr_busy}, 32'd1);
    chk("t5_len", pkt_len, 32'd3);
    wait_idle("t5_idle");
    chk("t5_nbeats", beat_d.size(), 32'd1);

    // START with dsize=0 is ignored
    clear_beats();
    cfg_dsize = 32'd0;
    pulse_start();
    chk("t6_busy", {31'd0, sr_busy}, 32'd0);
    chk("t6_pc", {31'd0, sr_pc}, 32'd1);
    send(7);
    chk("t6_tvalid", {31'd0, m_axis_tvalid}, 32'd0);

    // START during CAPTURE is ignored; latched config still governs
    clear_beats();
    cfg_ls = 1'b0; cfg_dsize = 32'd4;
    pulse_start();
    send(1); send(2);
    cfg_start = 1'b1; cfg_dsize = 32'd100; cfg_ls = 1'b1;
    send(3);
    cfg_start = 1'b0;
    send(4);
    chk("t7_tlast", {31'd0, m_axis_tlast}, 32'd1);
    chk("t7_len", pkt_len, 32'd4);
    wait_idle("t7_idle");
    chk("t7_nbeats", beat_d.size(), 32'd4);

    // Reset asserted mid-capture
    cfg_ls = 1'b0; cfg_dsize = 32'd100;
    pulse_start();
    send(9); send(10); send(11);
    #2 rst = 1'b1;
    #1;
    chk("t8_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("t8_busy", {31'd0, sr_busy}, 32'd0);
    chk("t8_pc", {31'd0, sr_pc}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
